// File: rtl/seq_det_pkg.sv
// ---------------------------------------------------------------------------
// seq_det_pkg: shared state type and default pattern for seq_detect_ctrl. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seq_det_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int         DEF_PAT_LEN = 5;
  localparam logic [4:0] DEF_PATTERN = 5'b11011;

endpackage

`default_nettype wire

// File: rtl/seq_match_core.sv
// ---------------------------------------------------------------------------
// seq_match_core: history register, fill counter and overlapping Mealy match. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_match_core #(
  parameter int                 PAT_LEN = 5,
  parameter logic [PAT_LEN-1:0] PATTERN = 5'b11011
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic bit_en,
  input  logic bit_in,
  output logic match
);

  localparam int                FILL_W   = $clog2(PAT_LEN);
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN - 1);

  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [PAT_LEN-1:0] window;

  // Window is the full candidate: previous PAT_LEN-1 bits plus the live bit.
  assign window = {hist_q, bit_in};
  assign match  = bit_en && (fill_q == FILL_MAX) && (window == PATTERN);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clear) begin
      hist_d = '0;
      fill_d = '0;
    end else if (bit_en) begin
      hist_d = window[PAT_LEN-2:0];
      if (fill_q != FILL_MAX) fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// seq_detect_ctrl: serialises words MSB first into the matcher, counts hits per word. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int                 W       = 8,
  parameter int                 PAT_LEN = DEF_PAT_LEN,
  parameter logic [PAT_LEN-1:0] PATTERN = DEF_PATTERN,
  parameter int                 CNT_W   = $clog2(W + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_keep,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_hit,
  output logic             busy
);

  localparam int             IDX_W    = $clog2(W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W - 1);

  state_t             state_q, state_d;
  logic [W-1:0]       shreg_q, shreg_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;

  logic accept;
  logic bit_en;
  logic core_clear;
  logic match;

  assign in_ready   = (state_q == ST_IDLE) && !clr;
  assign accept     = in_ready && in_valid;
  assign bit_en     = (state_q == ST_SHIFT) && !clr;
  assign core_clear = clr || (accept && !in_keep);

  assign busy      = (state_q != ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_count = out_valid ? cnt_q : '0;
  assign out_hit   = (out_count != '0);

  seq_match_core #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_core (
    .clk    (clk),
    .reset  (reset),
    .clear  (core_clear),
    .bit_en (bit_en),
    .bit_in (shreg_q[W-1]),
    .match  (match)
  );

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = in_data;
          idx_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shreg_d = {shreg_q[W-2:0], 1'b0};
        idx_d   = idx_q + IDX_W'(1);
        if (match) cnt_d = cnt_q + CNT_W'(1);
        if (idx_q == IDX_LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Flush overrides everything; any in-flight or pending result is lost.
    if (clr) state_d = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seq_detect_ctrl: directed and random checks of seq_detect_ctrl against a bit-queue model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seq_detect_ctrl;

  localparam int         W       = 8;
  localparam int         PAT_LEN = 5;
  localparam logic [4:0] PATTERN = 5'b11011;
  localparam int         CNT_W   = $clog2(W + 1);

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clr = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [W-1:0]     in_data = '0;
  logic             in_keep = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [CNT_W-1:0] out_count;
  logic             out_hit;
  logic             busy;

  int n_cmp = 0;
  int n_bad = 0;

  seq_detect_ctrl #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_count (out_count),
    .out_hit   (out_hit),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the word is either absent, being shifted (bits left > 0)
  // or waiting for the sink (bits left == 0). Counts come from a bit history.
  bit                 m_active = 1'b0;
  int                 m_left   = 0;
  int                 m_count  = 0;
  bit                 m_hist[$];
  logic [PAT_LEN-1:0] m_win;

  initial begin
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_active = 1'b0;
        m_left   = 0;
        m_count  = 0;
        m_hist.delete();
      end else if (clr) begin
        m_active = 1'b0;
        m_hist.delete();
      end else if (!m_active) begin
        if (in_valid) begin
          if (!in_keep) m_hist.delete();
          m_count = 0;
          for (int i = W - 1; i >= 0; i--) begin
            m_win = '0;
            foreach (m_hist[j]) m_win = {m_win[PAT_LEN-2:0], m_hist[j]};
            m_win = {m_win[PAT_LEN-2:0], in_data[i]};
            if (m_hist.size() == PAT_LEN - 1 && m_win == PATTERN) m_count++;
            m_hist.push_back(in_data[i]);
            if (m_hist.size() > PAT_LEN - 1) void'(m_hist.pop_front());
          end
          m_active = 1'b1;
          m_left   = W;
        end
      end else if (m_left > 0) begin
        m_left--;
      end else if (out_ready) begin
        m_active = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("in_ready", int'(in_ready), int'(!m_active && !clr));
      check("busy", int'(busy), int'(m_active));
      check("out_valid", int'(out_valid), int'(m_active && m_left == 0));
      if (m_active && m_left == 0) begin
        check("out_count", int'(out_count), m_count);
        check("out_hit", int'(out_hit), int'(m_count != 0));
      end
    end
  end

  // Offer a word and return one step after the accepting edge (T0).
  task automatic accept_word(input logic [W-1:0] d, input logic k);
    int guard = 0;
    @(negedge clk); #1;
    while (!in_ready && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    if (guard >= 50) check("accept_timeout", 0, 1);
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_word(input logic [W-1:0] d, input logic k, input int exp, input int hold);
    accept_word(d, k);
    for (int i = 1; i <= W; i++) begin
      @(posedge clk); #1;
      if (i == W - 1) check("valid_early", int'(out_valid), 0);
    end
    check("valid_at_TW", int'(out_valid), 1);
    check("word_count", int'(out_count), exp);
    check("word_hit", int'(out_hit), int'(exp != 0));
    in_valid = (hold > 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", int'(out_valid), 1);
      check("hold_count", int'(out_count), exp);
      check("hold_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("idle_after", int'(busy), 0);
  endtask

  initial begin
    #1;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_count", int'(out_count), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;

    run_word(8'b11011011, 1'b0, 2, 0);
    run_word(8'b00000011, 1'b0, 0, 0);
    run_word(8'b01100000, 1'b1, 1, 0);
    run_word(8'b01100000, 1'b0, 0, 0);
    run_word(8'hFF, 1'b0, 0, 0);
    run_word(8'h00, 1'b0, 0, 0);
    run_word(8'b11011011, 1'b0, 2, 5);

    // Flush on the 4th shift cycle; history must not survive into the next word.
    run_word(8'b00000011, 1'b0, 0, 0);
    accept_word(8'b11011011, 1'b1);
    repeat (3) @(posedge clk);
    #1 clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clr_busy", int'(busy), 0);
    check("clr_valid", int'(out_valid), 0);
    run_word(8'b01100000, 1'b1, 0, 0);

    // Reset in the middle of a word, then immediate accept after release.
    accept_word(8'b11011011, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_count", int'(out_count), 0);
    check("midrst_busy", int'(busy), 0);
    check("midrst_ready", int'(in_ready), 1);
    @(negedge clk); #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'b11011011;
    in_keep  = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("rst_release_accept", int'(busy), 1);
    begin
      int guard = 0;
      while (!out_valid && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      check("rst_word_count", int'(out_count), 2);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;

    for (int c = 0; c < 2500; c++) begin
      @(negedge clk); #1;
      in_valid  = ($urandom % 4) != 0;
      in_data   = W'($urandom);
      in_keep   = ($urandom % 3) != 0;
      out_ready = ($urandom % 3) != 0;
      clr       = ($urandom % 40) == 0;
    end
    @(negedge clk); #1;
    in_valid = 1'b0;
    clr      = 1'b0;
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
